pointer_hub: RTL

Parametrised multi-channel pointer aggregator between the PS/2 mouse decoders and `singleprocessor`. It replaces the per-mouse hardwiring (`mouse1x/mouse1y/isClicked1`, second channel tied to 0) with NUM_CH channels. Each channel has:
- a cursor accumulated from movement packets, clamped or wrapped to the canvas;
- frame-synchronous snapshots taken on `new_frame`;
- sticky click capture, so short presses are not lost;
- per-channel idle detection.

---
 rtl/pointer_hub.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/pointer_hub.sv
// ---------------------------------------------------------------------------
// pointer_hub
//
// Multi-channel pointer aggregator that sits between the PS/2 mouse decoders
// and the processor. Each channel keeps a live cursor built from movement
// packets. On every new_frame pulse the live state is copied into
// frame-stable outputs.
//
// Per-channel behaviour:
//   - cursor kept inside the canvas (clamped, or wrapped when the
//     POINTER_HUB_WRAP_EN macro is defined);
//   - sticky click capture, so a press shorter than a frame is still seen;
//   - idle detection after IDLE_FRAMES snapshots with no accepted packet.
//
// Configuration macro:
//   POINTER_HUB_WRAP_EN  defined -> out-of-range positions wrap around
//                        undefined -> positions saturate at the canvas edges
//
// Ports (channel i of a flattened bus lives at [i*W +: W]):
//   clk_in      in   system clock
//   rst_in      in   asynchronous active-high reset
//   pkt_valid   in   [NUM_CH]          one-cycle strobe per movement packet
//   pkt_dx      in   [NUM_CH*DELTA_W]  signed x delta, positive = right
//   pkt_dy      in   [NUM_CH*DELTA_W]  signed y delta, positive = up
//   pkt_btn     in   [NUM_CH]          left-button state in the packet
//   ch_en       in   [NUM_CH]          channel enable
//   recenter    in   [NUM_CH]          return cursor to X_INIT/Y_INIT
//   new_frame   in   frame-boundary pulse
//   pos_x       out  [NUM_CH*XW]       snapshotted x
//   pos_y       out  [NUM_CH*YW]       snapshotted y
//   click       out  [NUM_CH]          press began during the previous frame
//   held        out  [NUM_CH]          live button state
//   idle        out  [NUM_CH]          no packet for >= IDLE_FRAMES snapshots
//   snap_valid  out  one-cycle pulse after each snapshot
// ---------------------------------------------------------------------------
module pointer_hub #(
    parameter int NUM_CH        = 2,
    parameter int CANVAS_WIDTH  = 360,
    parameter int CANVAS_HEIGHT = 720,
    parameter int DELTA_W       = 9,
    parameter int X_INIT        = 180,
    parameter int Y_INIT        = 360,
    parameter int IDLE_FRAMES   = 60,
    localparam int XW = $clog2(CANVAS_WIDTH),
    localparam int YW = $clog2(CANVAS_HEIGHT)
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [NUM_CH-1:0]           pkt_valid,
    input  logic [NUM_CH*DELTA_W-1:0]   pkt_dx,
    input  logic [NUM_CH*DELTA_W-1:0]   pkt_dy,
    input  logic [NUM_CH-1:0]           pkt_btn,
    input  logic [NUM_CH-1:0]           ch_en,
    input  logic [NUM_CH-1:0]           recenter,
    input  logic                        new_frame,
    output logic [NUM_CH*XW-1:0]        pos_x,
    output logic [NUM_CH*YW-1:0]        pos_y,
    output logic [NUM_CH-1:0]           click,
    output logic [NUM_CH-1:0]           held,
    output logic [NUM_CH-1:0]           idle,
    output logic                        snap_valid
);

    // Signed working width: wide enough that position +/- delta never overflows.
    localparam int MW = (XW > YW) ? XW : YW;
    localparam int AW = ((MW > DELTA_W) ? MW : DELTA_W) + 2;
    localparam int CW = $clog2(IDLE_FRAMES + 1);

    localparam logic signed [AW-1:0] W_S  = AW'(CANVAS_WIDTH);
    localparam logic signed [AW-1:0] H_S  = AW'(CANVAS_HEIGHT);
    localparam logic signed [AW-1:0] XMAX = AW'(CANVAS_WIDTH - 1);
    localparam logic signed [AW-1:0] YMAX = AW'(CANVAS_HEIGHT - 1);
    localparam logic [XW-1:0]        X0   = XW'(X_INIT);
    localparam logic [YW-1:0]        Y0   = YW'(Y_INIT);
    localparam logic [CW-1:0]        IDLE_MAX = CW'(IDLE_FRAMES);

    // A single wrap correction is only enough if one delta cannot span a canvas.
    if ((1 << (DELTA_W - 1)) >= CANVAS_WIDTH || (1 << (DELTA_W - 1)) >= CANVAS_HEIGHT) begin : g_bad_delta
        $error("pointer_hub: 2^(DELTA_W-1) must be below both canvas dimensions");
    end
    if (IDLE_FRAMES < 1) begin : g_bad_idle
        $error("pointer_hub: IDLE_FRAMES must be at least 1");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [XW-1:0]          live_x, snap_x, fit_x;
        logic [YW-1:0]          live_y, snap_y, fit_y;
        logic                   btn_q, click_pend, click_q, idle_q;
        logic [CW-1:0]          idle_cnt, idle_nxt;
        logic                   accept, rise;
        logic [DELTA_W-1:0]     raw_dx, raw_dy;
        logic signed [AW-1:0]   nx, ny;

        assign raw_dx = pkt_dx[i*DELTA_W +: DELTA_W];
        assign raw_dy = pkt_dy[i*DELTA_W +: DELTA_W];
        assign accept = pkt_valid[i] & ch_en[i];
        assign rise   = accept & pkt_btn[i] & ~btn_q;

        // Candidate position; screen y grows downward, so the PS/2 dy is subtracted.
        always_comb begin
            nx = $signed({{(AW-XW){1'b0}}, live_x})
               + $signed({{(AW-DELTA_W){raw_dx[DELTA_W-1]}}, raw_dx});
            ny = $signed({{(AW-YW){1'b0}}, live_y})
               - $signed({{(AW-DELTA_W){raw_dy[DELTA_W-1]}}, raw_dy});
`ifdef POINTER_HUB_WRAP_EN
            if (nx[AW-1])        nx = nx + W_S;
            else if (nx > XMAX)  nx = nx - W_S;
            if (ny[AW-1])        ny = ny + H_S;
            else if (ny > YMAX)  ny = ny - H_S;
`else
            if (nx[AW-1])        nx = '0;
            else if (nx > XMAX)  nx = XMAX;
            if (ny[AW-1])        ny = '0;
            else if (ny > YMAX)  ny = YMAX;
`endif
            fit_x = nx[XW-1:0];
            fit_y = ny[YW-1:0];
        end

        // NOTE: every branch assigns idle_nxt, so no latch is inferred.
        always_comb begin
            if (accept)                     idle_nxt = '0;
            else if (idle_cnt == IDLE_MAX)  idle_nxt = idle_cnt;
            else                            idle_nxt = idle_cnt + CW'(1);
        end

        // NOTE: non-blocking assignments keep every register reading pre-edge values.
        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                live_x     <= X0;
                live_y     <= Y0;
                snap_x     <= X0;
                snap_y     <= Y0;
                btn_q      <= 1'b0;
                click_pend <= 1'b0;
                click_q    <= 1'b0;
                idle_cnt   <= IDLE_MAX;
                idle_q     <= 1'b1;
            end else begin
                // Recenter wins over a same-cycle packet for position only.
                if (recenter[i]) begin
                    live_x <= X0;
                    live_y <= Y0;
                end else if (accept) begin
                    live_x <= fit_x;
                    live_y <= fit_y;
                end

                if (!ch_en[i]) begin
                    btn_q      <= 1'b0;
                    click_pend <= 1'b0;
                end else begin
                    if (accept)
                        btn_q <= pkt_btn[i];
                    // A same-cycle edge goes straight into click, so the pending flag clears.
                    if (new_frame)
                        click_pend <= 1'b0;
                    else if (rise)
                        click_pend <= 1'b1;
                end

                if (accept || new_frame)
                    idle_cnt <= idle_nxt;

                if (new_frame) begin
                    snap_x  <= live_x;
                    snap_y  <= live_y;
                    click_q <= ch_en[i] & (click_pend | rise);
                    idle_q  <= (idle_nxt == IDLE_MAX);
                end
            end
        end

        assign pos_x[i*XW +: XW] = snap_x;
        assign pos_y[i*YW +: YW] = snap_y;
        assign click[i]          = click_q;
        assign held[i]           = btn_q;
        assign idle[i]           = idle_q;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) snap_valid <= 1'b0;
        else        snap_valid <= new_frame;
    end

endmodule
